map_request_server: RTL and testbench

- Responder end of the DDA map-fetch handshake. Accepts single-cycle map_request/map_addra pulses from a DDA core.
- Reads the maze cell from an external single-port map BRAM and returns it on map_data with a single-cycle map_data_ready.
- Also owns the write path used by the maze loader to fill the map BRAM between frames.
- Sits between the DDA core(s) and the map BRAM in the raycaster pipeline.

---
 rtl/map_request_server.sv | 118 +++++++++++
 tb/tb_map_request_server.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/map_request_server.sv
// map_request_server: serves DDA map-cell reads from a single-port BRAM and owns the loader write path.
// Ports: pixel_clk_in/rst_n_in clock and sync active-low reset; map_request/map_addra read pulse and
// cell address; map_data/map_data_ready returned cell and one-cycle valid; load_valid_in/load_addr_in/
// load_data_in/load_ready_out loader write handshake; bram_addr_out/bram_we_out/bram_din_out/bram_dout_in
// BRAM port; busy_out read in flight or pending; overflow_out sticky dropped-request flag.
module map_request_server #(
  parameter int N            = 24,
  parameter int DATA_WIDTH   = 3,
  parameter int BRAM_LATENCY = 2,
  parameter int WALL_VALUE   = 1
) (
  input  logic                       pixel_clk_in,
  input  logic                       rst_n_in,
  input  logic                       map_request,
  input  logic [$clog2(N*N)-1:0]     map_addra,
  output logic [DATA_WIDTH-1:0]      map_data,
  output logic                       map_data_ready,
  input  logic                       load_valid_in,
  input  logic [$clog2(N*N)-1:0]     load_addr_in,
  input  logic [DATA_WIDTH-1:0]      load_data_in,
  output logic                       load_ready_out,
  output logic [$clog2(N*N)-1:0]     bram_addr_out,
  output logic                       bram_we_out,
  output logic [DATA_WIDTH-1:0]      bram_din_out,
  input  logic [DATA_WIDTH-1:0]      bram_dout_in,
  output logic                       busy_out,
  output logic                       overflow_out
);
  localparam int AW = $clog2(N*N);
  localparam int CW = $clog2(BRAM_LATENCY+1);
  // one extra bit so N*N is representable even when it is a power of two
  localparam logic [AW:0] CELLS = (AW+1)'(N*N);
  typedef enum logic [1:0] {IDLE, READ_WAIT, RESPOND} state_t;
  state_t state_q, state_d;
  logic pend_v_q, pend_v_d, ovf_q, ovf_d, we_q, we_d;
  logic [AW-1:0] pend_a_q, pend_a_d, addr_q, addr_d, start_a;
  logic [DATA_WIDTH-1:0] data_q, data_d, din_q, din_d;
  logic [CW-1:0] cnt_q, cnt_d;
  assign start_a        = pend_v_q ? pend_a_q : map_addra;
  assign load_ready_out = (state_q == IDLE) & !map_request & !pend_v_q & rst_n_in;
  assign map_data       = data_q;
  assign map_data_ready = state_q == RESPOND;
  assign bram_addr_out  = addr_q;
  assign bram_we_out    = we_q;
  assign bram_din_out   = din_q;
  assign busy_out       = (state_q != IDLE) | pend_v_q;
  assign overflow_out   = ovf_q;
  always_comb begin
    state_d  = state_q;
    pend_v_d = pend_v_q;
    pend_a_d = pend_a_q;
    ovf_d    = ovf_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    addr_d   = addr_q;
    din_d    = din_q;
    we_d     = 1'b0;
    if (state_q == IDLE) begin
      if (pend_v_q | map_request) begin
        // serving the pending slot frees it; a same-cycle request refills it
        if (pend_v_q) begin
          pend_v_d = map_request;
          pend_a_d = map_addra;
        end
        if ({1'b0, start_a} < CELLS) begin
          addr_d  = start_a;
          cnt_d   = CW'(BRAM_LATENCY);
          state_d = READ_WAIT;
        end else begin
          data_d  = DATA_WIDTH'(WALL_VALUE);
          state_d = RESPOND;
        end
      end else if (load_valid_in && {1'b0, load_addr_in} < CELLS) begin
        we_d   = 1'b1;
        addr_d = load_addr_in;
        din_d  = load_data_in;
      end
    end else begin
      if (map_request) begin
        ovf_d    = ovf_q | pend_v_q;
        pend_v_d = 1'b1;
        pend_a_d = pend_v_q ? pend_a_q : map_addra;
      end
      if (state_q == RESPOND) begin
        state_d = IDLE;
      end else if (cnt_q == '0) begin
        // one edge of margin past BRAM_LATENCY before sampling the read data
        data_d  = bram_dout_in;
        state_d = RESPOND;
      end else begin
        cnt_d = cnt_q - CW'(1);
      end
    end
  end
  always_ff @(posedge pixel_clk_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      pend_v_q <= 1'b0;
      pend_a_q <= '0;
      ovf_q    <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      addr_q   <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      pend_v_q <= pend_v_d;
      pend_a_q <= pend_a_d;
      ovf_q    <= ovf_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      we_q     <= we_d;
    end
  end
endmodule

// File: tb/tb_map_request_server.sv
// tb_map_request_server: directed and random checks of map_request_server against a shadow map model.
module tb_map_request_server;
  localparam int NN   = 576;
  localparam int LAT  = 3;
  localparam int WALL = 1;
  logic clk = 1'b0, rst_n = 1'b0;
  logic map_request = 1'b0, load_valid = 1'b0;
  logic [9:0] map_addra = '0, load_addr = '0;
  logic [2:0] load_data = '0;
  logic [2:0] map_data, bram_din, bram_dout;
  logic map_data_ready, load_ready, bram_we, busy, overflow;
  logic [9:0] bram_addr;
  logic [2:0] mem [0:NN-1];
  logic [2:0] shadow [0:NN-1];
  logic [2:0] r1;
  int n_chk = 0, n_fail = 0;
  map_request_server dut (
    .pixel_clk_in(clk), .rst_n_in(rst_n), .map_request(map_request), .map_addra(map_addra),
    .map_data(map_data), .map_data_ready(map_data_ready), .load_valid_in(load_valid),
    .load_addr_in(load_addr), .load_data_in(load_data), .load_ready_out(load_ready),
    .bram_addr_out(bram_addr), .bram_we_out(bram_we), .bram_din_out(bram_din),
    .bram_dout_in(bram_dout), .busy_out(busy), .overflow_out(overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (bram_we && int'(bram_addr) < NN) mem[bram_addr] <= bram_din;
    r1        <= int'(bram_addr) < NN ? mem[bram_addr] : 3'd0;
    bram_dout <= r1;
  end
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(output int n);
    n = 0;
    while (map_data_ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    chk("ready_seen", 32'(map_data_ready), 32'd1);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_data"}, 32'(map_data), 0);
    chk({tag, "_ready"}, 32'(map_data_ready), 0);
    chk({tag, "_baddr"}, 32'(bram_addr), 0);
    chk({tag, "_bwe"}, 32'(bram_we), 0);
    chk({tag, "_bdin"}, 32'(bram_din), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
  endtask
  task automatic do_write(input logic [9:0] a, input logic [2:0] d);
    load_valid = 1'b1; load_addr = a; load_data = d;
    #1;
    chk("wr_ready", 32'(load_ready), 32'd1);
    tick;
    load_valid = 1'b0;
    chk("wr_we", 32'(bram_we), 32'(int'(a) < NN));
    if (int'(a) < NN) begin
      chk("wr_addr", 32'(bram_addr), 32'(a));
      chk("wr_din", 32'(bram_din), 32'(d));
      shadow[a] = d;
    end
    tick;
    chk("wr_we_off", 32'(bram_we), 0);
  endtask
  task automatic do_read(input logic [9:0] a);
    logic [2:0] e;
    logic [9:0] ba;
    int n;
    e  = int'(a) < NN ? shadow[a] : 3'(WALL);
    ba = bram_addr;
    map_request = 1'b1; map_addra = a;
    #1;
    chk("rd_ldrdy", 32'(load_ready), 0);
    tick;
    map_request = 1'b0;
    wait_ready(n);
    chk("rd_lat", 32'(n), int'(a) < NN ? LAT : 0);
    chk("rd_data", 32'(map_data), 32'(e));
    if (int'(a) >= NN) chk("oor_baddr", 32'(bram_addr), 32'(ba));
    tick;
    chk("rd_pulse", 32'(map_data_ready), 0);
    chk("rd_hold", 32'(map_data), 32'(e));
  endtask
  initial begin
    int n;
    for (int i = 0; i < NN; i++) begin
      mem[i] = '0;
      shadow[i] = '0;
    end
    tick; tick;
    chk_zero("rst");
    chk("rst_ldrdy", 32'(load_ready), 0);
    rst_n = 1'b1;
    tick;
    do_write(10'd25, 3'd5);
    do_read(10'd25);
    do_read(10'd0);
    do_write(10'd26, 3'd2);
    do_write(10'd50, 3'd7);
    do_write(10'd49, 3'd4);
    do_read(10'd26);
    do_read(10'd50);
    do_read(10'd49);
    do_read(10'd1);
    do_read(10'd576);
    do_write(10'd600, 3'd6);
    do_write(10'd10, 3'd2);
    do_write(10'd11, 3'd6);
    map_request = 1'b1; map_addra = 10'd10;
    tick;
    map_addra = 10'd11;
    tick;
    map_addra = 10'd12;
    tick;
    map_request = 1'b0;
    chk("b2b_ovf", 32'(overflow), 1);
    chk("b2b_busy", 32'(busy), 1);
    wait_ready(n);
    chk("b2b_d0", 32'(map_data), 2);
    tick;
    wait_ready(n);
    chk("b2b_d1", 32'(map_data), 6);
    chk("b2b_lat1", 32'(n), 4);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      tick;
      n += int'(map_data_ready);
    end
    chk("b2b_dropped", 32'(n), 0);
    chk("b2b_ovf_sticky", 32'(overflow), 1);
    chk("b2b_idle", 32'(busy), 0);
    load_valid = 1'b1; load_addr = 10'd30; load_data = 3'd7;
    map_request = 1'b1; map_addra = 10'd25;
    #1;
    chk("ct_ldrdy", 32'(load_ready), 0);
    tick;
    map_request = 1'b0;
    chk("ct_no_we", 32'(bram_we), 0);
    wait_ready(n);
    chk("ct_data", 32'(map_data), 5);
    n = 0;
    while (bram_we !== 1'b1 && n < 10) begin
      tick;
      n++;
    end
    load_valid = 1'b0;
    chk("ct_we", 32'(bram_we), 1);
    chk("ct_wait", 32'(n), 2);
    chk("ct_addr", 32'(bram_addr), 30);
    chk("ct_din", 32'(bram_din), 7);
    shadow[30] = 3'd7;
    tick;
    do_read(10'd30);
    map_request = 1'b1; map_addra = 10'd25;
    tick;
    map_addra = 10'd26;
    tick;
    map_request = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mr_ldrdy", 32'(load_ready), 0);
    tick;
    chk_zero("mr");
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      tick;
      n += int'(map_data_ready) + int'(busy);
    end
    chk("mr_quiet", 32'(n), 0);
    do_read(10'd25);
    for (int i = 0; i < 60; i++) begin
      logic [9:0] a;
      a = 10'($urandom_range(0, NN + 20));
      if ($urandom_range(0, 2) == 0) do_write(a, 3'($urandom_range(0, 7)));
      else do_read(a);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
